// File: rtl/kpn_fifo_reader_if.sv
// Bundles the FIFO read pins and the downstream valid/ready token stream
// of the KPN FIFO reader. master = reader side, slave = FIFO/consumer side.
interface kpn_fifo_reader_if #(
  parameter int BITS_NUMBER = 16
);
  logic                   fifo_empty;
  logic                   fifo_rd;
  logic [BITS_NUMBER-1:0] fifo_data;
  logic                   out_valid;
  logic [BITS_NUMBER-1:0] out_data;
  logic                   out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_rd,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_rd,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/kpn_fifo_reader.sv
// Blocking-read controller: pops the KPN token FIFO into a small skid buffer
// and presents a valid/ready stream. Optional stall counter: KPN_READER_STATS_EN.
module kpn_fifo_reader #(
  parameter int BITS_NUMBER = 16,
  parameter int BUF_DEPTH   = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 flush_i,
  kpn_fifo_reader_if.master    bus,
  output logic [CNT_WIDTH-1:0] tokens_read_o,
`ifdef KPN_READER_STATS_EN
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
`endif
  output logic [1:0]           state_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_STARVED = 2'd2,
    ST_BACKP   = 2'd3
  } state_e;

  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic                   inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]   tokens_q, tokens_d;
  state_e                 state_q, state_d;
  logic [BITS_NUMBER-1:0] mem_q [BUF_DEPTH];

  logic [OCC_W-1:0] level_s;
  logic             rd_s;
  logic             capture_s;
  logic             pop_s;

  // Reserved space counts the in-flight token so a read can never overflow the buffer.
  assign level_s   = occ_q + OCC_W'(inflight_q);
  assign rd_s      = rst_n & enable_i & ~flush_i & ~bus.fifo_empty & (level_s < DEPTH_C);
  assign capture_s = inflight_q & ~flush_i;
  assign pop_s     = (occ_q != '0) & bus.out_ready & ~flush_i;

  assign bus.fifo_rd    = rd_s;
  assign bus.out_valid  = (occ_q != '0);
  assign bus.out_data   = mem_q[rptr_q];
  assign tokens_read_o  = tokens_q;
  assign state_o        = state_q;

  // Next-state for occupancy, pointers, in-flight flag and consumed counter.
  always_comb begin
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = rd_s;
    tokens_d   = tokens_q;
    if (flush_i) begin
      occ_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      inflight_d = 1'b0;
    end else begin
      if (capture_s) begin
        wptr_d = wptr_q + PTR_W'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d   = rptr_q + PTR_W'(1);
        tokens_d = tokens_q + CNT_WIDTH'(1);
      end else begin
        rptr_d   = rptr_q;
        tokens_d = tokens_q;
      end
      case ({capture_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Reporting state; evaluated from current registered occupancy.
  always_comb begin
    state_d = ST_FETCH;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (level_s == DEPTH_C) begin
      state_d = ST_BACKP;
    end else if (bus.fifo_empty && (occ_q == '0) && !inflight_q) begin
      state_d = ST_STARVED;
    end else begin
      state_d = ST_FETCH;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      tokens_q   <= '0;
      state_q    <= ST_IDLE;
    end else begin
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      tokens_q   <= tokens_d;
      state_q    <= state_d;
    end
  end

  // Token storage; FIFO data is valid exactly one cycle after the pop strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture_s) begin
      mem_q[wptr_q] <= bus.fifo_data;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

`ifdef KPN_READER_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  // Saturating count of starved cycles.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_STARVED) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_kpn_fifo_reader.sv
// Randomized bench for kpn_fifo_reader: an upstream FIFO model feeds the DUT and
// a queue-based reference of the reader checks every output each cycle.
module tb_kpn_fifo_reader;
  localparam int BW = 16;
  localparam int BD = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] tokens_read;
  logic [1:0]    state;
`ifdef KPN_READER_STATS_EN
  logic [CW-1:0] stall_cycles;
`endif

  kpn_fifo_reader_if #(.BITS_NUMBER(BW)) bus ();

  kpn_fifo_reader #(.BITS_NUMBER(BW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .flush_i       (flush),
    .bus           (bus.master),
    .tokens_read_o (tokens_read),
`ifdef KPN_READER_STATS_EN
    .stall_cycles_o(stall_cycles),
`endif
    .state_o       (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [BW-1:0] src_q[$];
  logic [BW-1:0] next_tok = 16'h0001;

  logic [BW-1:0] ref_q[$];
  bit            ref_infl = 1'b0;
  logic [BW-1:0] ref_infl_val = '0;
  int            ref_tokens = 0;
  int            ref_state = 0;
  int            ref_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit en, input bit fl, input bit rdy, input int pushes);
    bit   exp_rd;
    bit   rd_dut;
    bit   empty;
    int   lvl;
    int   nxt_state;
    logic [BW-1:0] popped;
    @(negedge clk);
    for (int i = 0; i < pushes; i++) begin
      src_q.push_back(next_tok);
      next_tok++;
    end
    empty         = (src_q.size() == 0);
    enable        = en;
    flush         = fl;
    bus.out_ready = rdy;
    bus.fifo_empty = empty;
    #1;
    lvl    = ref_q.size() + int'(ref_infl);
    exp_rd = rst_n && en && !fl && !empty && (lvl < BD);
    rd_dut = bus.fifo_rd;
    check("fifo_rd", 32'(rd_dut), 32'(exp_rd));
    check("out_valid", 32'(bus.out_valid), 32'(ref_q.size() != 0));
    if (ref_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(ref_q[0]));
    check("tokens_read", 32'(tokens_read), 32'(ref_tokens % 65536));
    check("state", 32'(state), 32'(ref_state));
`ifdef KPN_READER_STATS_EN
    check("stall_cycles", 32'(stall_cycles), 32'(ref_stall));
`endif
    if (!rst_n) begin
      ref_q.delete();
      ref_infl   = 1'b0;
      ref_tokens = 0;
      ref_state  = 0;
      ref_stall  = 0;
    end else begin
      if (!en) nxt_state = 0;
      else if (lvl == BD) nxt_state = 3;
      else if (empty && ref_q.size() == 0 && !ref_infl) nxt_state = 2;
      else nxt_state = 1;
      if (ref_state == 2 && ref_stall < 65535) ref_stall++;
      if (fl) begin
        ref_q.delete();
        ref_infl = 1'b0;
      end else begin
        if (ref_q.size() != 0 && rdy) begin
          void'(ref_q.pop_front());
          ref_tokens++;
        end
        if (ref_infl) ref_q.push_back(ref_infl_val);
        ref_infl = exp_rd;
        if (exp_rd) ref_infl_val = src_q[0];
      end
      ref_state = nxt_state;
    end
    @(posedge clk);
    popped = 16'($urandom);
    if (rd_dut && src_q.size() != 0) popped = src_q.pop_front();
    #1;
    bus.fifo_data = popped;
  endtask

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.out_ready  = 1'b0;

    // Reset with a non-empty FIFO and enable high: nothing may move.
    step(1'b1, 1'b0, 1'b1, 8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 0);
    rst_n = 1'b1;

    // Streaming tokens 1..8 out.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 0);
    check("stream_count", 32'(tokens_read), 32'd8);

    // Backpressure: 5 tokens, consumer stalled, then released.
    step(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 0);
    check("bp_state", 32'(state), 32'd3);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1, 0);
    check("bp_count", 32'(tokens_read), 32'd13);

    // 20 tokens with a 1,0,1,1,0 ready pattern across pointer wrap.
    step(1'b1, 1'b0, 1'b1, 20);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, (i % 5 != 1) && (i % 5 != 4), 0);

    // Flush the cycle after a read.
    step(1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom % 8) != 0, ($urandom % 20) == 0, $urandom % 2, int'($urandom % 2));

    // Drain, then starve for 10 cycles and sit idle for 5.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
